// File: rtl/branch_resolve_if.sv
// Bus between branch resolution, fetch redirect, the predictor-update port and the statistics outputs.
// master = the environment around branch_resolve; slave = branch_resolve itself.
interface branch_resolve_if #(
    parameter int unsigned AWID = 64
);
    logic            br_v;
    logic            takb;
    logic            pred_taken;
    logic [AWID-1:0] br_pc;
    logic [AWID-1:0] br_tgt;
    logic            redirect_v;
    logic [AWID-1:0] redirect_pc;
    logic            upd_v;
    logic            upd_rdy;
    logic [AWID-1:0] upd_pc;
    logic            upd_taken;
    logic            br_stall;
    logic [31:0]     br_cnt;
    logic [31:0]     mis_cnt;

    modport master (
        output br_v, takb, pred_taken, br_pc, br_tgt, upd_rdy,
        input  redirect_v, redirect_pc, upd_v, upd_pc, upd_taken, br_stall, br_cnt, mis_cnt
    );

    modport slave (
        input  br_v, takb, pred_taken, br_pc, br_tgt, upd_rdy,
        output redirect_v, redirect_pc, upd_v, upd_pc, upd_taken, br_stall, br_cnt, mis_cnt
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution: mispredict redirect pulse plus a FIFO of predictor updates.
// Optional macro BRANCH_STATS_EN adds accepted-branch and mispredict counters.
module branch_resolve #(
    parameter int unsigned AWID   = 64,
    parameter int unsigned QDEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    branch_resolve_if.slave bus
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AWID-1:0] q_pc    [QDEPTH];
    logic            q_taken [QDEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   occ;

    logic accept;
    logic mispredict;
    logic full;
    logic empty;
    logic push;
    logic pop;

    // Branches seen during a redirect pulse are on the wrong path.
    assign accept     = bus.br_v & ~bus.redirect_v;
    assign mispredict = accept & (bus.takb ^ bus.pred_taken);
    assign full       = (occ == CW'(QDEPTH));
    assign empty      = (occ == '0);
    assign pop        = ~empty & bus.upd_rdy;
    // A full queue still takes the push if the head leaves in the same cycle.
    assign push       = accept & (~full | pop);

    assign bus.upd_v     = ~empty;
    assign bus.upd_pc    = q_pc[rd_ptr];
    assign bus.upd_taken = q_taken[rd_ptr];
    assign bus.br_stall  = full;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.redirect_v  <= 1'b0;
            bus.redirect_pc <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            occ             <= '0;
        end else begin
            bus.redirect_v <= mispredict;
            if (mispredict) begin
                bus.redirect_pc <= bus.takb ? bus.br_tgt : bus.br_pc + AWID'(5);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                occ <= occ + CW'(1);
            end else if (pop && !push) begin
                occ <= occ - CW'(1);
            end
        end
    end

    // Queue storage needs no reset; validity is tracked by occ.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= bus.br_pc;
            q_taken[wr_ptr] <= bus.takb;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mis_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (accept) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (mispredict) begin
                mis_cnt_q <= mis_cnt_q + 32'd1;
            end
        end
    end

    assign bus.br_cnt  = br_cnt_q;
    assign bus.mis_cnt = mis_cnt_q;
`else
    assign bus.br_cnt  = '0;
    assign bus.mis_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed branches push expected redirects/updates,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_branch_resolve;
    localparam int unsigned AWID   = 64;
    localparam int unsigned QDEPTH = 4;
`ifdef BRANCH_STATS_EN
    localparam logic [31:0] EXP_BR  = 32'd10;
    localparam logic [31:0] EXP_MIS = 32'd3;
`else
    localparam logic [31:0] EXP_BR  = 32'd0;
    localparam logic [31:0] EXP_MIS = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    branch_resolve_if #(.AWID(AWID)) bus ();

    branch_resolve #(.AWID(AWID), .QDEPTH(QDEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [AWID-1:0] exp_redir_q [$];
    logic [AWID:0]   exp_upd_q   [$];
    logic [AWID-1:0] mon_rpc;
    logic [AWID:0]   mon_upd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one branch for one cycle and record what the bench expects from it.
    task automatic br(input logic [63:0] pc, input logic [63:0] tgt, input logic t, input logic p,
                      input logic exp_r, input logic [63:0] exp_rpc, input logic exp_u);
        bus.br_v       = 1'b1;
        bus.br_pc      = pc;
        bus.br_tgt     = tgt;
        bus.takb       = t;
        bus.pred_taken = p;
        if (exp_r) exp_redir_q.push_back(exp_rpc);
        if (exp_u) exp_upd_q.push_back({pc, t});
        tick();
        bus.br_v = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.redirect_v === 1'b1) begin
                if (exp_redir_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL redirect_unexpected got pc %h expected no redirect", bus.redirect_pc);
                end else begin
                    mon_rpc = exp_redir_q.pop_front();
                    chk("redirect_pc", bus.redirect_pc, mon_rpc);
                end
            end
            if (bus.upd_v === 1'b1 && bus.upd_rdy === 1'b1) begin
                if (exp_upd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL upd_unexpected got pc %h expected no update", bus.upd_pc);
                end else begin
                    mon_upd = exp_upd_q.pop_front();
                    chk("upd_pc", bus.upd_pc, mon_upd[AWID:1]);
                    chk("upd_taken", 64'(bus.upd_taken), 64'(mon_upd[0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.br_v = 1'b0; bus.takb = 1'b0; bus.pred_taken = 1'b0;
        bus.br_pc = '0; bus.br_tgt = '0; bus.upd_rdy = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_redirect_v", 64'(bus.redirect_v), 64'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 64'd0);
        chk("rst_upd_v", 64'(bus.upd_v), 64'd0);
        chk("rst_br_stall", 64'(bus.br_stall), 64'd0);
        chk("rst_br_cnt", 64'(bus.br_cnt), 64'd0);
        chk("rst_mis_cnt", 64'(bus.mis_cnt), 64'd0);
        rst = 1'b0;
        tick();

        // Taken mispredict: redirect to target for exactly one cycle.
        br(64'h100, 64'h1000, 1'b1, 1'b0, 1'b1, 64'h1000, 1'b1);
        chk("redir_pulse", 64'(bus.redirect_v), 64'd1);
        tick();
        chk("redir_end", 64'(bus.redirect_v), 64'd0);
        chk("redir_hold", bus.redirect_pc, 64'h1000);
        chk("one_entry_pc", bus.upd_pc, 64'h100);
        bus.upd_rdy = 1'b1; tick(); bus.upd_rdy = 1'b0;
        chk("drained_1", 64'(bus.upd_v), 64'd0);

        // Not-taken mispredict, then a wrong-path branch during the redirect.
        br(64'h2000, 64'h9999, 1'b0, 1'b1, 1'b1, 64'h2005, 1'b1);
        br(64'h3000, 64'h4000, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        chk("wrong_path_no_redir", 64'(bus.redirect_v), 64'd0);
        chk("wrong_path_upd_v", 64'(bus.upd_v), 64'd1);
        bus.upd_rdy = 1'b1; tick(); bus.upd_rdy = 1'b0;
        chk("wrong_path_dropped", 64'(bus.upd_v), 64'd0);

        // Fall-through address wraps modulo 2^AWID.
        br(64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1'b0, 1'b1, 1'b1, 64'h2, 1'b1);
        tick();
        bus.upd_rdy = 1'b1; tick(); bus.upd_rdy = 1'b0;

        // Fill the queue with correct predictions.
        for (int i = 1; i <= 4; i++) begin
            br(64'(i * 16), 64'd0, 1'(i % 2), 1'(i % 2), 1'b0, 64'd0, 1'b1);
        end
        chk("full_stall", 64'(bus.br_stall), 64'd1);
        chk("full_head_pc", bus.upd_pc, 64'h10);
        chk("full_head_taken", 64'(bus.upd_taken), 64'd1);
        bus.upd_rdy = 1'b1;
        br(64'h50, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        bus.upd_rdy = 1'b0;
        chk("full_pushpop_stall", 64'(bus.br_stall), 64'd1);
        chk("full_pushpop_head", bus.upd_pc, 64'h20);

        // Full, no pop: mispredict still redirects, its update is dropped.
        br(64'h60, 64'h6000, 1'b1, 1'b0, 1'b1, 64'h6000, 1'b0);
        chk("full_mis_redir", 64'(bus.redirect_v), 64'd1);
        tick();
        chk("full_mis_stall", 64'(bus.br_stall), 64'd1);
        chk("full_mis_head_pc", bus.upd_pc, 64'h20);
        chk("full_mis_head_taken", 64'(bus.upd_taken), 64'd0);
        bus.upd_rdy = 1'b1;
        repeat (4) tick();
        chk("drain_upd_v", 64'(bus.upd_v), 64'd0);
        chk("drain_stall", 64'(bus.br_stall), 64'd0);
        tick();
        chk("empty_rdy_upd_v", 64'(bus.upd_v), 64'd0);

        // Counters: 10 accepted branches, 3 of them mispredicted.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 1) begin
                br(64'(32'h800 + i * 4), 64'(32'h900 + i * 16), 1'b1, 1'b0,
                   1'b1, 64'(32'h900 + i * 16), 1'b1);
                tick();
            end else begin
                br(64'(32'h800 + i * 4), 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
            end
        end
        tick();
        chk("br_cnt", 64'(bus.br_cnt), 64'(EXP_BR));
        chk("mis_cnt", 64'(bus.mis_cnt), 64'(EXP_MIS));

        // Reset mid-operation drops a queued update and the pending redirect.
        bus.upd_rdy = 1'b0;
        br(64'hA00, 64'hB00, 1'b1, 1'b0, 1'b1, 64'hB00, 1'b1);
        chk("pre_rst_upd_v", 64'(bus.upd_v), 64'd1);
        rst = 1'b1;
        tick();
        exp_redir_q.delete();
        exp_upd_q.delete();
        chk("mid_rst_redirect_v", 64'(bus.redirect_v), 64'd0);
        chk("mid_rst_upd_v", 64'(bus.upd_v), 64'd0);
        chk("mid_rst_br_cnt", 64'(bus.br_cnt), 64'd0);
        chk("mid_rst_mis_cnt", 64'(bus.mis_cnt), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_upd_v", 64'(bus.upd_v), 64'd0);
        chk("redir_sb_empty", 64'(exp_redir_q.size()), 64'd0);
        chk("upd_sb_empty", 64'(exp_upd_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter AWID, default 64: width of PC and target addresses.
REQ-002 Parameter QDEPTH, default 4: depth of the predictor-update queue (power of two, at least 2).
REQ-003 Port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port br_v, input, 1: a resolved-branch record is presented this cycle.
REQ-006 Port takb, input, 1: branch-taken result from branch condition evaluation.
REQ-007 Port pred_taken, input, 1: the fetch-time prediction for this branch.
REQ-008 Port br_pc, input, AWID: address of the branch instruction.
REQ-009 Port br_tgt, input, AWID: taken-path target address.
REQ-010 Port redirect_v, output, 1: one-cycle mispredict redirect pulse.
REQ-011 Port redirect_pc, output, AWID: correct fetch address that accompanies redirect_v.
REQ-012 Port upd_v, output, 1: head entry of the update queue is valid.
REQ-013 Port upd_rdy, input, 1: the predictor accepts the head entry.
REQ-014 Port upd_pc, output, AWID: pc field of the head entry.
REQ-015 Port upd_taken, output, 1: taken field of the head entry.
REQ-016 Port br_stall, output, 1: update queue is full; upstream holds br_v low.
REQ-017 Port br_cnt, output, 32: count of accepted branches.
REQ-018 Port mis_cnt, output, 32: count of mispredicts.

Function
REQ-019 A branch is accepted in cycle N when br_v=1 and redirect_v=0; branches arriving while redirect_v=1 are wrong-path and are discarded with no effect.
REQ-020 An accepted branch is a mispredict when takb differs from pred_taken.
REQ-021 For a mispredict accepted in cycle N, redirect_v=1 in cycle N+1 only, with redirect_pc = br_tgt if takb=1, else br_pc+5 (modulo 2^AWID).
REQ-022 redirect_pc holds its last value while redirect_v=0.
REQ-023 Every accepted branch pushes {br_pc, takb} into the FIFO update queue, whether or not it mispredicted.
REQ-024 upd_v=1 whenever the queue is non-empty; upd_pc and upd_taken show the oldest entry, combinationally from storage.
REQ-025 An entry is popped when upd_v=1 and upd_rdy=1 in the same cycle.
REQ-026 br_stall=1 exactly when the occupancy equals QDEPTH.
REQ-027 Push and pop in the same cycle leave occupancy unchanged; this includes the full case, where the push is accepted.
REQ-028 When full, an accepted branch with no simultaneous pop still produces its redirect, but its update is dropped and occupancy is unchanged.
REQ-029 An empty queue with upd_rdy=1 produces no pop and no state change.
REQ-030 Read and write pointers wrap modulo QDEPTH.

Reset
REQ-031 While rst=1: redirect_v=0, redirect_pc=0, queue emptied (upd_v=0, br_stall=0), pointers=0, br_cnt=0, mis_cnt=0.
REQ-032 Reset asserted mid-operation discards all queued entries and any pending redirect, and has priority over every other input.

Configuration
REQ-033 With macro BRANCH_STATS_EN defined:
- br_cnt increments on each accepted branch.
- mis_cnt increments on each mispredict.
- both wrap at 2^32.
REQ-034 With BRANCH_STATS_EN undefined, br_cnt and mis_cnt are constant 0 and no counter registers exist.

Verification
REQ-035 Reset, then br_v=1, takb=1, pred_taken=0, br_tgt=0x1000 -> next cycle redirect_v=1, redirect_pc=0x1000; the cycle after, redirect_v=0.
REQ-036 br_v=1, takb=0, pred_taken=1, br_pc=0x2000, then br_v=1 in the redirect cycle -> redirect_pc=0x2005; the second branch is discarded (queue holds 1 entry).
REQ-037 Push 4 correct predictions with upd_rdy=0 -> br_stall=1, upd_pc is the first pc; raise upd_rdy and push together -> occupancy stays 4, order preserved.
REQ-038 Full queue, upd_rdy=0, mispredict branch -> redirect generated, queue contents unchanged.
REQ-039 BRANCH_STATS_EN on: 10 branches with 3 mispredicts -> br_cnt=10, mis_cnt=3; assert rst -> both 0 and upd_v=0 next cycle.
